// File: rtl/mem_controller_pkg.sv
// rtl/mem_controller_pkg.sv - shared types and constants for the backing-memory controller
package mem_ctrl_pkg;

  localparam int WAIT_CNT_W     = 4;
  localparam int RAM_AW_DEFAULT = 10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE   = 3'd2;
  localparam logic [2:0] ST_RD_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESP       = 3'd4;
  localparam logic [2:0] ST_GAP        = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WR_ISSUE   = ST_WR_ISSUE,
    RD_ISSUE   = ST_RD_ISSUE,
    RD_CAPTURE = ST_RD_CAPTURE,
    RESP       = ST_RESP,
    GAP        = ST_GAP
  } state_t;

endpackage

// File: rtl/mem_controller_if.sv
// rtl/mem_controller_if.sv - cache-to-memory miss link (err member present with MEM_CTRL_BOUNDS_CHECK_EN)
interface mem_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cache2mem_MemRead;
  logic              cache2mem_MemWrite;
  logic [ADDR_W-1:0] cache2mem_rd_addr;
  logic [ADDR_W-1:0] cache2mem_wb_addr;
  logic [DATA_W-1:0] cache2mem_wb_data;
  logic [DATA_W-1:0] mem2cache_data;
  logic              mem2cache_ready;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  logic              mem2cache_err;

  modport master (
    output cache2mem_MemRead, cache2mem_MemWrite, cache2mem_rd_addr,
           cache2mem_wb_addr, cache2mem_wb_data,
    input  mem2cache_data, mem2cache_ready, mem2cache_err
  );
  modport slave (
    input  cache2mem_MemRead, cache2mem_MemWrite, cache2mem_rd_addr,
           cache2mem_wb_addr, cache2mem_wb_data,
    output mem2cache_data, mem2cache_ready, mem2cache_err
  );
`else
  modport master (
    output cache2mem_MemRead, cache2mem_MemWrite, cache2mem_rd_addr,
           cache2mem_wb_addr, cache2mem_wb_data,
    input  mem2cache_data, mem2cache_ready
  );
  modport slave (
    input  cache2mem_MemRead, cache2mem_MemWrite, cache2mem_rd_addr,
           cache2mem_wb_addr, cache2mem_wb_data,
    output mem2cache_data, mem2cache_ready
  );
`endif
endinterface

// File: rtl/mem_controller_wait_counter.sv
// rtl/mem_controller_wait_counter.sv - load/decrement wait-state counter with zero flag
module mem_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_load_val,
  input  logic                  i_dec,
  output logic                  o_zero
);

  logic [WAIT_CNT_W-1:0] r_count;

  // load on ISSUE entry, otherwise count down and saturate at zero
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - write-back/fill sequencer for a wait-stated RAM; optional MEM_CTRL_BOUNDS_CHECK_EN
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OFFSET_W    = 2,
  parameter int RAM_AW      = RAM_AW_DEFAULT,
  parameter int WAIT_STATES = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  mem_controller_if.slave   cache_if,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WORD_LO = OFFSET_W;
  localparam int WORD_HI = OFFSET_W + RAM_AW - 1;
  localparam logic [WAIT_CNT_W-1:0] LP_WAIT = WAIT_CNT_W'(WAIT_STATES);

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_load, w_dec, w_start_rd, w_capture, w_cnt_zero;
  logic [RAM_AW-1:0] w_wb_word, w_rd_word, r_rd_word, r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_data;
  logic              r_ram_we, r_ram_re, r_rd_pend, r_rd_oob;
  logic              w_wb_oob, w_rd_oob, w_unused_addr;

  assign w_wb_word = cache_if.cache2mem_wb_addr[WORD_HI:WORD_LO];
  assign w_rd_word = cache_if.cache2mem_rd_addr[WORD_HI:WORD_LO];

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  assign w_wb_oob = |cache_if.cache2mem_wb_addr[ADDR_W-1:WORD_HI+1];
  assign w_rd_oob = |cache_if.cache2mem_rd_addr[ADDR_W-1:WORD_HI+1];
  assign w_unused_addr = ^{cache_if.cache2mem_wb_addr[WORD_LO-1:0],
                           cache_if.cache2mem_rd_addr[WORD_LO-1:0]};
`else
  // upper address bits alias onto the RAM
  assign w_wb_oob = 1'b0;
  assign w_rd_oob = 1'b0;
  assign w_unused_addr = ^{cache_if.cache2mem_wb_addr[ADDR_W-1:WORD_HI+1],
                           cache_if.cache2mem_wb_addr[WORD_LO-1:0],
                           cache_if.cache2mem_rd_addr[ADDR_W-1:WORD_HI+1],
                           cache_if.cache2mem_rd_addr[WORD_LO-1:0]};
`endif

  mem_wait_counter u_wait_cnt (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .i_load     (w_load),
    .i_load_val (LP_WAIT),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  // state register
  always_ff @(posedge iCLK) begin
    if (!iRST_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_start_rd  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cache_if.cache2mem_MemWrite) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = WR_ISSUE;
        end else if (cache_if.cache2mem_MemRead) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (!w_cnt_zero) begin
          w_dec = 1'b1;
        end else if (r_rd_pend) begin
          w_load      = 1'b1;
          w_start_rd  = 1'b1;
          w_state_nxt = RD_ISSUE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      RD_ISSUE: begin
        if (!w_cnt_zero) w_dec = 1'b1;
        else             w_state_nxt = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // request capture, single-cycle RAM strobes with held address/data, fill capture
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_word   <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_oob    <= 1'b0;
      r_data      <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_ram_re <= 1'b0;
      if (w_accept) begin
        r_rd_word <= w_rd_word;
        r_rd_pend <= cache_if.cache2mem_MemRead;
        r_rd_oob  <= cache_if.cache2mem_MemRead & w_rd_oob;
        if (cache_if.cache2mem_MemWrite) begin
          r_ram_addr  <= w_wb_word;
          r_ram_wdata <= cache_if.cache2mem_wb_data;
          r_ram_we    <= ~w_wb_oob;
        end else begin
          r_ram_addr <= w_rd_word;
          r_ram_re   <= ~w_rd_oob;
        end
      end
      if (w_start_rd) begin
        r_ram_addr <= r_rd_word;
        r_ram_re   <= ~r_rd_oob;
      end
      if (w_capture) begin
        r_data <= r_rd_oob ? '0 : ram_rdata;
      end
    end
  end

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  logic r_oob_any, r_err;

  // err clears on acceptance and is raised together with the ready pulse
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_oob_any <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_oob_any <= (cache_if.cache2mem_MemWrite & w_wb_oob) |
                   (cache_if.cache2mem_MemRead  & w_rd_oob);
      r_err     <= 1'b0;
    end else if (w_state_nxt == RESP) begin
      r_err <= r_oob_any;
    end
  end

  assign cache_if.mem2cache_err = r_err;
`endif

  assign cache_if.mem2cache_data  = r_data;
  assign cache_if.mem2cache_ready = (r_state == RESP);
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign ram_re    = r_ram_re;

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed checks on three controllers with WAIT_STATES 0, 1 and 2
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_rd, req_wr;
  logic [31:0] rd_addr, wb_addr, wb_data;
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  logic [2:0]  o_ready, o_we, o_re, o_err;
  logic [9:0]  o_addr  [3];
  logic [31:0] o_wdata [3];
  logic [31:0] o_data  [3];

  int checks = 0;
  int failures = 0;

  int t_cwe, t_cre, t_crdy, t_nrdy, t_nwe, t_nre, t_awe, t_are, t_err;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_controller_if #(.ADDR_W(32), .DATA_W(32)) cif ();
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we, ram_re;
    logic [31:0] mem [1024];

    assign cif.cache2mem_MemRead  = req_rd[gi];
    assign cif.cache2mem_MemWrite = req_wr[gi];
    assign cif.cache2mem_rd_addr  = rd_addr;
    assign cif.cache2mem_wb_addr  = wb_addr;
    assign cif.cache2mem_wb_data  = wb_data;

    mem_controller #(
      .ADDR_W(32), .DATA_W(32), .OFFSET_W(2), .RAM_AW(10), .WAIT_STATES(gi)
    ) u_dut (
      .iCLK      (clk),
      .iRST_n    (rst_n),
      .cache_if  (cif),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
      if (pl_we)  mem[pl_addr]  <= pl_data;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata     <= mem[ram_addr];
    end

    assign o_ready[gi] = cif.mem2cache_ready;
    assign o_we[gi]    = ram_we;
    assign o_re[gi]    = ram_re;
    assign o_addr[gi]  = ram_addr;
    assign o_wdata[gi] = ram_wdata;
    assign o_data[gi]  = cif.mem2cache_data;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    assign o_err[gi]   = cif.mem2cache_err;
`else
    assign o_err[gi]   = 1'b0;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // cycle 0 is the negedge where the request is raised; samples at later negedges are cycles 1..24
  task automatic run_txn(input int k, input logic wr, input logic rd,
                         input logic [31:0] wba, input logic [31:0] wbd,
                         input logic [31:0] rda, input bit hold_gap);
    @(negedge clk);
    wb_addr = wba; wb_data = wbd; rd_addr = rda;
    req_wr[k] = wr; req_rd[k] = rd;
    t_cwe = -1; t_cre = -1; t_crdy = -1; t_nrdy = 0; t_nwe = 0; t_nre = 0;
    t_awe = -1; t_are = -1; t_err = -1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (o_we[k]) begin
        t_nwe++;
        if (t_cwe < 0) begin t_cwe = cyc; t_awe = int'(o_addr[k]); end
      end
      if (o_re[k]) begin
        t_nre++;
        if (t_cre < 0) begin t_cre = cyc; t_are = int'(o_addr[k]); end
      end
      if (o_ready[k]) begin
        t_nrdy++;
        if (t_crdy < 0) begin t_crdy = cyc; t_err = int'(o_err[k]); end
      end
      if (t_crdy >= 0 && (!hold_gap || cyc == t_crdy + 1)) begin
        req_wr[k] = 1'b0; req_rd[k] = 1'b0;
      end
    end
    req_wr[k] = 1'b0; req_rd[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_rd = '0; req_wr = '0;
    rd_addr = '0; wb_addr = '0; wb_data = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_ready", {29'd0, o_ready}, 32'd0);
    check_eq("rst_we",    {29'd0, o_we},    32'd0);
    check_eq("rst_re",    {29'd0, o_re},    32'd0);
    check_eq("rst_err",   {29'd0, o_err},   32'd0);
    check_eq("rst_addr1", {22'd0, o_addr[1]}, 32'd0);
    check_eq("rst_wdata1", o_wdata[1], 32'd0);
    check_eq("rst_data1",  o_data[1],  32'd0);
    rst_n = 1'b1;

    preload(10'd5,  32'hDEADBEEF);
    preload(10'd16, 32'hCAFEF00D);
    preload(10'd7,  32'h77665544);

    // read-only, W=2
    run_txn(2, 1'b0, 1'b1, 32'h0, 32'h0, 32'h14, 1'b0);
    check_eq("rd_re_cycle", t_cre,  32'd1);
    check_eq("rd_re_addr",  t_are,  32'd5);
    check_eq("rd_re_count", t_nre,  32'd1);
    check_eq("rd_we_count", t_nwe,  32'd0);
    check_eq("rd_rdy_cycle", t_crdy, 32'd5);
    check_eq("rd_rdy_count", t_nrdy, 32'd1);
    check_eq("rd_data",     o_data[2], 32'hDEADBEEF);

    // write-back + fill, W=1
    run_txn(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h40, 1'b0);
    check_eq("wf_we_cycle", t_cwe,  32'd1);
    check_eq("wf_we_addr",  t_awe,  32'd8);
    check_eq("wf_re_cycle", t_cre,  32'd3);
    check_eq("wf_re_addr",  t_are,  32'd16);
    check_eq("wf_rdy_cycle", t_crdy, 32'd6);
    check_eq("wf_rdy_count", t_nrdy, 32'd1);
    check_eq("wf_data",     o_data[1], 32'hCAFEF00D);
    check_eq("wf_ram8",     g_dut[1].mem[8], 32'h12345678);

    // same address write-back + fill, W=0
    run_txn(0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 32'h10, 1'b0);
    check_eq("sa_we_cycle", t_cwe,  32'd1);
    check_eq("sa_re_cycle", t_cre,  32'd2);
    check_eq("sa_rdy_cycle", t_crdy, 32'd4);
    check_eq("sa_data",     o_data[0], 32'hA5A5A5A5);

    // write-only, W=1
    run_txn(1, 1'b1, 1'b0, 32'h30, 32'h0BADF00D, 32'h0, 1'b0);
    check_eq("wo_we_cycle", t_cwe,  32'd1);
    check_eq("wo_we_addr",  t_awe,  32'd12);
    check_eq("wo_re_count", t_nre,  32'd0);
    check_eq("wo_rdy_cycle", t_crdy, 32'd3);
    check_eq("wo_ram12",    g_dut[1].mem[12], 32'h0BADF00D);
    check_eq("wo_data_held", o_data[1], 32'hCAFEF00D);

    // request held through ready and GAP, W=0
    run_txn(0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 1'b1);
    check_eq("hold_rdy_cycle", t_crdy, 32'd3);
    check_eq("hold_rdy_count", t_nrdy, 32'd1);
    check_eq("hold_re_count",  t_nre,  32'd1);
    check_eq("hold_data",      o_data[0], 32'hCAFEF00D);

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    run_txn(1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0001_0000, 1'b0);
    check_eq("oob_re_count", t_nre,  32'd0);
    check_eq("oob_rdy_cycle", t_crdy, 32'd4);
    check_eq("oob_err",      t_err,  32'd1);
    check_eq("oob_data",     o_data[1], 32'd0);
    run_txn(1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h14, 1'b0);
    check_eq("inr_err",      t_err,  32'd0);
    check_eq("inr_data",     o_data[1], 32'hDEADBEEF);
`else
    run_txn(2, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0001_001C, 1'b0);
    check_eq("alias_re_addr", t_are, 32'd7);
    check_eq("alias_rdy_cycle", t_crdy, 32'd5);
    check_eq("alias_data",    o_data[2], 32'h77665544);
`endif

    // reset during RD_ISSUE, W=2
    @(negedge clk);
    rd_addr = 32'h14; req_rd[2] = 1'b1;
    @(negedge clk);
    check_eq("mid_re_issued", {31'd0, o_re[2]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; req_rd[2] = 1'b0;
    @(negedge clk);
    check_eq("mid_ready", {31'd0, o_ready[2]}, 32'd0);
    check_eq("mid_re",    {31'd0, o_re[2]},    32'd0);
    check_eq("mid_addr",  {22'd0, o_addr[2]},  32'd0);
    check_eq("mid_data2", o_data[2], 32'd0);
    check_eq("mid_data1", o_data[1], 32'd0);
    rst_n = 1'b1;
    t_nrdy = 0; t_nre = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (o_ready[2]) t_nrdy++;
      if (o_re[2])    t_nre++;
    end
    check_eq("mid_no_ready", t_nrdy, 32'd0);
    check_eq("mid_no_re",    t_nre,  32'd0);

    run_txn(2, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0);
    check_eq("post_rdy_cycle", t_crdy, 32'd5);
    check_eq("post_data",      o_data[2], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
# mem_controller

Backing-memory controller directly downstream of the cache controller. It accepts the cache's miss traffic: an optional write-back of a dirty line, then an optional line fill. It performs these accesses on a single-port synchronous on-chip RAM with a configurable number of wait states. It returns fill data with a one-cycle ready pulse, so the cache can leave ALLOCATE/WRITE_BACK.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width (one word per cache line)
- OFFSET_W, 2, byte-offset bits dropped to form the word address
- RAM_AW, 10, RAM word-address width (1024 words)
- WAIT_STATES, 1, extra RAM cycles per access, legal 0..15

Ports:
- iCLK  in  1  clock; all logic on rising edge
- iRST_n  in  1  reset, synchronous, active-low
- cache2mem_MemRead  in  1  fill request, level, held until ready
- cache2mem_MemWrite  in  1  write-back request, level, held until ready
- cache2mem_rd_addr  in  ADDR_W  fill byte address
- cache2mem_wb_addr  in  ADDR_W  write-back byte address
- cache2mem_wb_data  in  DATA_W  write-back data
- mem2cache_data  out  DATA_W  fill data, held until next fill capture
- mem2cache_ready  out  1  one-cycle completion pulse
- mem2cache_err  out  1  only with MEM_CTRL_BOUNDS_CHECK_EN; qualifies ready
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_re

## Operation
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RESP, GAP.
- IDLE: samples MemWrite/MemRead. It registers both addresses, the write data and a read-pending flag.
  - MemWrite=1 -> WR_ISSUE.
  - MemRead only -> RD_ISSUE.
  - Neither -> stay in IDLE.
- Word address is addr[OFFSET_W+RAM_AW-1:OFFSET_W]; upper bits are ignored unless the macro is defined.
- WR_ISSUE:
  - ram_we=1 in the first cycle only; ram_addr and ram_wdata are held for 1+WAIT_STATES cycles.
  - Then go to RD_ISSUE if read-pending, else RESP.
- RD_ISSUE:
  - ram_re=1 in the first cycle only; ram_addr is held for 1+WAIT_STATES cycles.
  - Then go to RD_CAPTURE.
- RD_CAPTURE: registers ram_rdata into mem2cache_data -> RESP.
- RESP: mem2cache_ready=1 for exactly one cycle -> GAP.
- GAP: one mandatory cycle that ignores requests, so the still-high request seen in the ready cycle is not re-accepted -> IDLE.
- Request inputs are not sampled outside IDLE. Changes mid-transaction are ignored.

## Timing
- Reset (iRST_n=0 at an edge): state=IDLE, wait counter=0. mem2cache_data=0, mem2cache_ready=0, mem2cache_err=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0.
- Reset mid-transaction: aborted at that edge. A RAM write already issued stays done; no further RAM strobes; no ready pulse.
- W = WAIT_STATES, and the sampling IDLE cycle is cycle 0.
- Read-only: ram_re in cycle 1, capture in cycle W+2, ready in cycle W+3.
- Write-only: ram_we in cycle 1, ready in cycle W+2.
- Write + read: ram_we in cycle 1, ram_re in cycle W+2, capture in cycle 2W+3, ready in cycle 2W+4.
- Earliest next acceptance: two cycles after ready (GAP, then IDLE).
- Write-back address equal to fill address: the read returns the just-written data.
- Wait counter width is 4 bits. It loads W on entry to each ISSUE state and counts down to 0. W=0 gives a single-cycle ISSUE.

## Configuration
- MEM_CTRL_BOUNDS_CHECK_EN defined:
  - An address is out of range if its bits above OFFSET_W+RAM_AW-1 are nonzero.
  - An out-of-range access issues no RAM strobe for that access.
  - An out-of-range fill sets mem2cache_data=0.
  - The transaction completes with normal latency and mem2cache_err=1 alongside ready.
  - err clears on the next accepted request.
- Undefined: mem2cache_err port absent; upper address bits silently ignored (aliasing).

## Structure
- Shared package mem_ctrl_pkg holds:
  - the state encoding localparams (3-bit)
  - the wait-counter width (4)
  - the default RAM_AW
- One natural sub-module, mem_wait_counter: load/decrement/zero-flag counter used by both ISSUE states.
- The RAM itself is outside the block.

## Test plan
- Read-only: W=2, RAM[5]=0xDEADBEEF, MemRead with rd_addr=0x14 -> ram_re in cycle 1, ready only in cycle 5, mem2cache_data=0xDEADBEEF.
- Write-back + fill: W=1, wb_addr=0x20 with data 0x12345678, rd_addr=0x40 holding 0xCAFEF00D -> ram_we cycle 1 at word 8, ram_re cycle 3 at word 16, ready in cycle 6 with 0xCAFEF00D, RAM[8]=0x12345678.
- Same address: W=0, wb_addr=rd_addr=0x10 with data 0xA5A5A5A5 -> fill returns 0xA5A5A5A5, ready in cycle 4.
- Held request: MemRead held high through ready and GAP -> exactly one ready pulse; reacceptance only when the request is seen in IDLE.
- Reset mid-operation: iRST_n low during RD_ISSUE -> no ready, all outputs 0 after the edge, a following request completes normally.
- Bounds (macro on): rd_addr=0x0001_0000 with RAM_AW=10 -> no ram_re, ready with err=1 and data=0; a subsequent in-range read gives err=0.
